attr_interpolator: RTL and testbench
====================================

ATTR_INTERPOLATOR -- requirements
Module: attr_interpolator

Parameters
REQ-001 The block SHALL have parameter CHANNELS, default 3, giving the number of independent attribute channels interpolated per pixel.
REQ-002 The block SHALL have parameter W, default 27, giving the width of each channel value (two's-complement fixed point, binary point irrelevant to the block).
REQ-003 The block SHALL have parameter TILE_BITS, default 5, giving a tile of 2^TILE_BITS x 2^TILE_BITS pixels.

Interface
REQ-004 clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 in_valid  in  1  plane-equation set presented.
REQ-007 in_ready  out  1  block accepts a plane-equation set this cycle.
REQ-008 in_c  in  CHANNELS*W  per-channel value at pixel (0,0); channel k in bits [k*W +: W].
REQ-009 in_dadx  in  CHANNELS*W  per-channel step for x+1, same packing.
REQ-010 in_dady  in  CHANNELS*W  per-channel step for y+1, same packing.
REQ-011 out_valid  out  1  pixel result presented.
REQ-012 out_ready  in  1  downstream accepts the pixel this cycle.
REQ-013 out_x, out_y  out  TILE_BITS each  pixel coordinate within the tile.
REQ-014 out_attr  out  CHANNELS*W  interpolated values, same packing as in_c.
REQ-015 out_last  out  1  current pixel is (max,max), the final pixel of the tile.
REQ-016 busy  out  1  a tile walk is in progress (state WALK).

Function
REQ-017 The block SHALL implement two states, IDLE and WALK.
REQ-018 Input transfer SHALL occur when in_valid && in_ready; output transfer when out_valid && out_ready.
REQ-019 in_ready SHALL be 1 in IDLE, and in WALK only in a cycle where the out_last pixel is being transferred; 0 otherwise.
REQ-020 On an input transfer the block SHALL latch in_c/in_dadx/in_dady, set x=0, y=0, current value = in_c, row base = in_c, and be in WALK with out_valid=1 the next cycle (latency one cycle).
REQ-021 out_valid SHALL equal 1 exactly in WALK; out_x, out_y, out_attr, out_last SHALL hold stable while out_valid && !out_ready.
REQ-022 On an output transfer with x < max: x <= x+1, current <= current + dadx (per channel).
REQ-023 On an output transfer with x = max, y < max: x <= 0, y <= y+1, row base <= row base + dady, current <= row base + dady.
REQ-024 On an output transfer with x = y = max: go to IDLE, unless an input transfer occurs the same cycle, in which case REQ-020 applies and WALK continues with no idle cycle.
REQ-025 Pixels SHALL be emitted in raster order (x fastest), one per cycle when out_ready is held high; 4^TILE_BITS transfers per tile.
REQ-026 Every emitted value SHALL equal c + x*dadx + y*dady modulo 2^W per channel, computed with adders only (no multipliers); overflow wraps silently.
REQ-027 Channels SHALL be independent; no channel value SHALL affect another.
REQ-028 in_valid with in_ready=0 SHALL leave all state unchanged; upstream holds its data.

Reset
REQ-029 While rst=1 and asynchronously on its assertion: state=IDLE, x=y=0, all latched and accumulated values 0, out_valid=0, out_last=0, busy=0, out_attr=0, out_x=out_y=0; in_ready=1 after reset.
REQ-030 rst asserted mid-walk SHALL abort the tile; no further pixels of it SHALL be emitted after release.

Verification
REQ-031 CHANNELS=1, c=100, dadx=1, dady=32, out_ready=1 -> 1024 pixels, values 100..1123 in order, first one cycle after acceptance, out_last only on value 1123 at (31,31).
REQ-032 Same tile with out_ready randomly toggled (~50%) -> identical sequence, outputs stable during every stall, no pixel dropped or duplicated.
REQ-033 CHANNELS=3, channel0 c=2^26-1, dadx=1 -> (1,0) gives -2^26 (wrap); channel1 dadx=-3, dady=5 -> (31,31) gives c1+62; channel2 all zero -> constant 0.
REQ-034 Two sets offered back-to-back, in_valid held, out_ready=1 -> second set accepted on the out_last cycle of the first, 2048 consecutive output cycles with no gap.
REQ-035 rst pulsed at pixel (7,3) -> out_valid=0 immediately, busy=0, in_ready=1 after release; next tile starts at (0,0) with its own c.

Source files
------------

// File: rtl/attr_interpolator.sv
// attr_interpolator: walks a 2^TILE_BITS x 2^TILE_BITS tile in raster order
// and emits c + x*dadx + y*dady per channel, using running adders only.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   plane-equation handshake (in_c, in_dadx, in_dady)
//   in_c                per-channel value at pixel (0,0), channel k at [k*W +: W]
//   in_dadx, in_dady    per-channel x and y steps, same packing
//   out_valid/out_ready pixel handshake
//   out_x, out_y        pixel coordinate within the tile
//   out_attr            interpolated values, same packing as in_c
//   out_last            current pixel is the final (max,max) pixel
//   busy                a tile walk is in progress
module attr_interpolator #(
   parameter int CHANNELS  = 3,
   parameter int W         = 27,
   parameter int TILE_BITS = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [CHANNELS*W-1:0]   in_c,
   input  logic [CHANNELS*W-1:0]   in_dadx,
   input  logic [CHANNELS*W-1:0]   in_dady,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [TILE_BITS-1:0]    out_x,
   output logic [TILE_BITS-1:0]    out_y,
   output logic [CHANNELS*W-1:0]   out_attr,
   output logic                    out_last,
   output logic                    busy
);

   localparam int CW = CHANNELS * W;
   localparam logic [TILE_BITS-1:0] MAXC = '1;
   localparam logic [TILE_BITS-1:0] ONE = {{(TILE_BITS-1){1'b0}}, 1'b1};
   localparam logic [TILE_BITS-1:0] PENULT = MAXC - ONE;

   typedef enum logic {IDLE, WALK} state_t;

   state_t        state;
   logic [CW-1:0] dadx_q;
   logic [CW-1:0] dady_q;
   logic [CW-1:0] row_q;
   logic [CW-1:0] step_x;
   logic [CW-1:0] step_y;
   logic          out_xfer;
   logic          in_xfer;
   logic          x_end;
   logic          y_end;

   // Per-channel adders; each W-bit sum wraps on its own so
   // no carry ever crosses into a neighbouring channel.
   always_comb begin
      step_x = '0;
      step_y = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         step_x[k*W +: W] = out_attr[k*W +: W] + dadx_q[k*W +: W];
         step_y[k*W +: W] = row_q[k*W +: W] + dady_q[k*W +: W];
      end
   end

   assign out_xfer = out_valid && out_ready;
   assign x_end    = (out_x == MAXC);
   assign y_end    = (out_y == MAXC);

   // A new set can be taken while the final pixel leaves, so
   // back-to-back tiles run without an idle cycle.
   assign in_ready = (state == IDLE) || (out_xfer && out_last);
   assign in_xfer  = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         dadx_q    <= '0;
         dady_q    <= '0;
         row_q     <= '0;
         out_attr  <= '0;
         out_x     <= '0;
         out_y     <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
      end else if (in_xfer) begin
         state     <= WALK;
         dadx_q    <= in_dadx;
         dady_q    <= in_dady;
         row_q     <= in_c;
         out_attr  <= in_c;
         out_x     <= '0;
         out_y     <= '0;
         out_valid <= 1'b1;
         out_last  <= (MAXC == '0);
         busy      <= 1'b1;
      end else if (out_xfer) begin
         if (!x_end) begin
            out_x    <= out_x + ONE;
            out_attr <= step_x;
            // Registered look-ahead: next pixel is last when it
            // lands on column max of the last row.
            out_last <= y_end && (out_x == PENULT);
         end else if (!y_end) begin
            out_x    <= '0;
            out_y    <= out_y + ONE;
            row_q    <= step_y;
            out_attr <= step_y;
            out_last <= (MAXC == '0) && (out_y == PENULT);
         end else begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_attr_interpolator.sv
// tb_attr_interpolator: directed tiles with a scoreboard queue and a
// decoupled output monitor for attr_interpolator.
module tb_attr_interpolator;

   localparam int CH = 3;
   localparam int W  = 27;
   localparam int TB = 5;
   localparam int CW = CH * W;
   localparam int NS = 1 << TB;
   localparam int PW = 2 * TB + 1 + CW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [CW-1:0] in_c = '0;
   logic [CW-1:0] in_dadx = '0;
   logic [CW-1:0] in_dady = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [TB-1:0] out_x;
   logic [TB-1:0] out_y;
   logic [CW-1:0] out_attr;
   logic          out_last;
   logic          busy;

   always #5 clk = ~clk;

   attr_interpolator #(.CHANNELS(CH), .W(W), .TILE_BITS(TB)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_c(in_c),
      .in_dadx(in_dadx),
      .in_dady(in_dady),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_x(out_x),
      .out_y(out_y),
      .out_attr(out_attr),
      .out_last(out_last),
      .busy(busy)
   );

   typedef struct packed {
      logic [TB-1:0] x;
      logic [TB-1:0] y;
      logic          last;
      logic [CW-1:0] attr;
   } pix_t;

   pix_t sb[$];
   int   ntotal = 0;
   int   npass = 0;
   bit   rnd = 1'b0;
   int   cyc = 0;
   int   nxfer = 0;
   int   mark = -1;
   int   first_cyc = 0;
   int   last_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [PW-1:0] act,
                      input logic [PW-1:0] exp);
      ntotal++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   function automatic logic [CW-1:0] pack3(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [W-1:0] c);
      return {c, b, a};
   endfunction

   function automatic pix_t model(input logic [CW-1:0] c,
                                  input logic [CW-1:0] dx,
                                  input logic [CW-1:0] dy,
                                  input int x, input int y);
      pix_t p;
      p.x = TB'(x);
      p.y = TB'(y);
      p.last = (x == NS - 1) && (y == NS - 1);
      p.attr = '0;
      for (int k = 0; k < CH; k++)
         p.attr[k*W +: W] = c[k*W +: W] + dx[k*W +: W] * W'(x)
                            + dy[k*W +: W] * W'(y);
      return p;
   endfunction

   // Issue one plane-equation set; expectations are queued at the
   // cycle the handshake is seen, before the transfer edge.
   task automatic send(input logic [CW-1:0] c, input logic [CW-1:0] dx,
                       input logic [CW-1:0] dy);
      int n = 0;
      in_c = c;
      in_dadx = dx;
      in_dady = dy;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         ntotal++;
         $display("FAIL accept_timeout: in_ready stayed 0");
      end else begin
         for (int y = 0; y < NS; y++)
            for (int x = 0; x < NS; x++)
               sb.push_back(model(c, dx, dy, x, y));
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20000) begin
         ntotal++;
         $display("FAIL drain_timeout: %0d pixels outstanding", sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1 out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: samples mid-cycle; a transfer happens on the next rising
   // edge exactly when out_valid && out_ready is seen here.
   initial begin
      pix_t held;
      pix_t exp;
      pix_t cur;
      bit   stall = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         cur = '{x: out_x, y: out_y, last: out_last, attr: out_attr};
         if (stall) begin
            chk("stall_valid", PW'(out_valid), PW'(1));
            chk("stall_hold", PW'(cur), PW'(held));
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               ntotal++;
               $display("FAIL unexpected_pixel: x=%0d y=%0d attr=%h",
                        out_x, out_y, out_attr);
            end else begin
               exp = sb.pop_front();
               chk("pix", PW'(cur), PW'(exp));
            end
            if (nxfer == mark) first_cyc = cyc;
            nxfer++;
            last_cyc = cyc;
         end
         stall = out_valid && !out_ready;
         held = cur;
      end
   end

   initial begin
      int n;
      logic [CW-1:0] ca, dxa, dya;
      ca  = pack3(W'(100), W'(-500), W'(7));
      dxa = pack3(W'(1), W'(3), W'(-1));
      dya = pack3(W'(32), W'(-7), W'(100));

      #12;
      chk("rst_in_ready", PW'(in_ready), PW'(1));
      chk("rst_out_valid", PW'(out_valid), PW'(0));
      chk("rst_busy", PW'(busy), PW'(0));
      chk("rst_out_last", PW'(out_last), PW'(0));
      chk("rst_out_attr", PW'(out_attr), PW'(0));
      chk("rst_out_xy", PW'({out_x, out_y}), PW'(0));
      @(posedge clk);
      #1 rst = 1'b0;

      // Unstalled ramp tile.
      send(ca, dxa, dya);
      wait_drain();

      // Same tile, random backpressure.
      rnd = 1'b1;
      send(ca, dxa, dya);
      wait_drain();
      rnd = 1'b0;

      // Wrap, negative step, all-zero channel.
      send(pack3(W'(67108863), W'(1000), W'(0)),
           pack3(W'(1), W'(-3), W'(0)),
           pack3(W'(0), W'(5), W'(0)));
      wait_drain();

      // Back-to-back sets with no gap between tiles.
      mark = nxfer;
      send(pack3(W'(5), W'(-9), W'(123)),
           pack3(W'(2), W'(4), W'(-8)),
           pack3(W'(64), W'(-1), W'(3)));
      send(pack3(W'(-77), W'(1), W'(42)),
           pack3(W'(-1), W'(11), W'(6)),
           pack3(W'(9), W'(-2), W'(-6)));
      wait_drain();
      chk("b2b_count", PW'(nxfer - mark), PW'(2 * NS * NS));
      chk("b2b_nogap", PW'(last_cyc - first_cyc), PW'(2 * NS * NS - 1));
      mark = -1;

      // Reset in the middle of a walk at pixel (7,3).
      send(pack3(W'(1), W'(2), W'(3)),
           pack3(W'(1), W'(1), W'(1)),
           pack3(W'(1), W'(1), W'(1)));
      n = 0;
      @(negedge clk);
      while (!(out_valid && out_x == 7 && out_y == 3) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("mid_reach_7_3", PW'({out_valid, out_x, out_y}),
          PW'({1'b1, TB'(7), TB'(3)}));
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_valid", PW'(out_valid), PW'(0));
      chk("mid_rst_busy", PW'(busy), PW'(0));
      chk("mid_rst_attr", PW'(out_attr), PW'(0));
      chk("mid_rst_xy_last", PW'({out_x, out_y, out_last}), PW'(0));
      sb.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", PW'(in_ready), PW'(1));
      chk("post_rst_valid", PW'(out_valid), PW'(0));
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1;
      send(pack3(W'(-1000), W'(31), W'(500)),
           pack3(W'(7), W'(-1), W'(2)),
           pack3(W'(-13), W'(0), W'(1)));
      wait_drain();

      chk("sb_empty", PW'(sb.size()), PW'(0));
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
